// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns that transforms COLS_PER_CYCLE columns per clock behind valid/ready.
// When i_skip is set the state passes through unchanged, with the same latency and handshake.
//
//  state | meaning
//  IDLE  | o_ready=1, waiting to latch i_state / i_skip
//  BUSY  | transforming one column group per clock into o_state
//  DONE  | o_valid=1, o_state held until i_ready
module inv_mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_state,
    input  logic         i_skip,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_state
);
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state;
    logic [1:0]   col;
    logic [127:0] work;
    logic         skip;
    logic [127:0] next_result;
    logic [1:0]   col_idx;
    logic [31:0]  col_word;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Each multiply is assembled from the x2/x4/x8 chain of its own input byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = c[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_comb begin
        next_result = o_state;
        col_idx     = '0;
        col_word    = '0;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            col_idx  = col + 2'(g);
            col_word = work[127 - 32*int'(col_idx) -: 32];
            next_result[127 - 32*int'(col_idx) -: 32] = skip ? col_word : inv_mix_col(col_word);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            col     <= '0;
            work    <= '0;
            skip    <= 1'b0;
            o_state <= '0;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        work    <= i_state;
                        skip    <= i_skip;
                        col     <= '0;
                        o_ready <= 1'b0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    o_state <= next_result;
                    if (col == LAST_COL) begin
                        col     <= '0;
                        o_valid <= 1'b1;
                        state   <= DONE;
                    end else begin
                        col <= col + COL_STEP;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Scoreboard bench for inv_mix_columns_iter: a GF(2^8) long-division reference model feeds
// an expected-result queue that a negedge monitor drains whenever a result is handed off.
`timescale 1ns/1ps
module tb_inv_mix_columns_iter;
    localparam int CPC = 1;
    localparam int L   = 4 / CPC;
    localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] SKIP_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_valid = 1'b0;
    logic         i_skip = 1'b0;
    logic         i_ready = 1'b0;
    logic [127:0] i_state = '0;
    logic         o_ready, o_valid;
    logic [127:0] o_state;

    logic         v2 = 1'b0, v4 = 1'b0;
    logic [127:0] sweep_state = '0;
    logic         or2, ov2, or4, ov4;
    logic [127:0] os2, os4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit btb = 1'b0;
    logic [127:0] exp_q[$];
    int           acc_q[$];

    logic         prev_v = 1'b0;
    logic         prev_rdy = 1'b0;
    logic [127:0] prev_state = '0;

    inv_mix_columns_iter #(.COLS_PER_CYCLE(CPC)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_state(i_state),
        .i_skip(i_skip), .o_valid(o_valid), .i_ready(i_ready), .o_state(o_state));

    inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(or2), .i_state(sweep_state),
        .i_skip(1'b0), .o_valid(ov2), .i_ready(1'b1), .o_state(os2));

    inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(v4), .o_ready(or4), .i_state(sweep_state),
        .i_skip(1'b0), .o_valid(ov4), .i_ready(1'b1), .o_state(os4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: carry-less product reduced by polynomial long division.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_imc(input logic [127:0] s, input logic skip);
        logic [7:0]   coef [4];
        logic [7:0]   a    [4];
        logic [7:0]   b;
        logic [127:0] res;
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        res  = s;
        if (!skip) begin
            for (int c = 0; c < 4; c++) begin
                for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
                for (int r = 0; r < 4; r++) begin
                    b = 8'h00;
                    for (int k = 0; k < 4; k++) b = b ^ gmul(coef[(k - r + 4) % 4], a[k]);
                    res[127 - 32*c - 8*r -: 8] = b;
                end
            end
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, why);
    endtask

    task automatic send(input logic [127:0] d, input logic s, input logic [127:0] exp, output int acc);
        int n;
        n = 0;
        acc = -1;
        @(negedge clk);
        while (!o_ready && n < 100) begin
            i_valid = btb;
            i_state = {$urandom, $urandom, $urandom, $urandom};
            i_skip  = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (!o_ready) begin
            fail_now("send_timeout", "o_ready stayed 0, expected 1 within 100 cycles");
            return;
        end
        i_valid = 1'b1;
        i_state = d;
        i_skip  = s;
        acc     = cyc + 1;
        exp_q.push_back(exp);
        acc_q.push_back(acc);
        @(posedge clk);
        #1;
        i_valid = btb;
        i_state = {$urandom, $urandom, $urandom, $urandom};
        i_skip  = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input bit rnd);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge clk);
            #1;
            if (rnd) i_ready = 1'($urandom_range(0, 1));
            n++;
        end
        if (exp_q.size() > 0) begin
            fail_now("drain_timeout", $sformatf("%0d results pending, expected 0", exp_q.size()));
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    always @(negedge clk) begin
        int a;
        if (!rst) begin
            if (o_valid && !prev_v) begin
                if (acc_q.size() > 0) begin
                    a = acc_q.pop_front();
                    chk("latency", 128'(cyc - a), 128'(L));
                end else begin
                    fail_now("unexpected_valid", "o_valid rose with no accepted block");
                end
            end
            if (o_valid) chk("ready_low_in_done", 128'(o_ready), 128'(0));
            if (o_valid && prev_v && !prev_rdy) chk("hold_stable", o_state, prev_state);
            if (o_valid && i_ready) begin
                if (exp_q.size() > 0) chk("result", o_state, exp_q.pop_front());
                else fail_now("extra_result", "result handed off with empty scoreboard");
            end
        end
        prev_v     <= o_valid;
        prev_rdy   <= i_ready;
        prev_state <= o_state;
    end

    initial begin
        int acc;
        int accs [3];
        int lat2, lat4;
        logic [127:0] st2, st4, d;
        logic s;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_valid", 128'(o_valid), 128'(0));
        chk("reset_state", o_state, 128'(0));
        chk("reset_ready", 128'(o_ready), 128'(1));

        // FIPS vector and skip
        i_ready = 1'b1;
        send(FIPS_IN, 1'b0, FIPS_OUT, acc);
        drain(1'b0);
        send(SKIP_IN, 1'b1, SKIP_IN, acc);
        drain(1'b0);

        // Backpressure in DONE
        i_ready = 1'b0;
        d = {$urandom, $urandom, $urandom, $urandom};
        send(d, 1'b0, ref_imc(d, 1'b0), acc);
        for (int n = 0; n < 50 && !o_valid; n++) begin
            @(posedge clk);
            #1;
        end
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            chk("bp_valid_held", 128'(o_valid), 128'(1));
            chk("bp_ready_low", 128'(o_ready), 128'(0));
        end
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_valid_falls", 128'(o_valid), 128'(0));
        chk("bp_drained", 128'(exp_q.size()), 128'(0));

        // Back-to-back with i_valid/i_ready held high
        btb = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            s = 1'(k == 1);
            send(d, s, ref_imc(d, s), accs[k]);
        end
        btb = 1'b0;
        i_valid = 1'b0;
        drain(1'b0);
        chk("btb_period_1", 128'(accs[1] - accs[0]), 128'(L + 2));
        chk("btb_period_2", 128'(accs[2] - accs[1]), 128'(L + 2));

        // Reset during BUSY
        d = {$urandom, $urandom, $urandom, $urandom};
        send(d, 1'b0, ref_imc(d, 1'b0), acc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 128'(o_valid), 128'(0));
        chk("rst_mid_state", o_state, 128'(0));
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst = 1'b0;
        d = {$urandom, $urandom, $urandom, $urandom};
        send(d, 1'b0, ref_imc(d, 1'b0), acc);
        drain(1'b0);

        // Randomized blocks with random downstream stalls
        for (int k = 0; k < 16; k++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            s = 1'($urandom_range(0, 3) == 0);
            send(d, s, ref_imc(d, s), acc);
            drain(1'b1);
        end
        i_ready = 1'b1;

        // COLS_PER_CYCLE sweep on the FIPS vector
        @(negedge clk);
        chk("sweep_ready2", 128'(or2), 128'(1));
        chk("sweep_ready4", 128'(or4), 128'(1));
        sweep_state = FIPS_IN;
        v2 = 1'b1;
        v4 = 1'b1;
        @(posedge clk);
        #1;
        v2 = 1'b0;
        v4 = 1'b0;
        lat2 = -1;
        lat4 = -1;
        st2  = '0;
        st4  = '0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (ov2 && lat2 < 0) begin lat2 = n; st2 = os2; end
            if (ov4 && lat4 < 0) begin lat4 = n; st4 = os4; end
        end
        chk("sweep_lat2", 128'(lat2), 128'(2));
        chk("sweep_lat4", 128'(lat4), 128'(1));
        chk("sweep_state2", st2, FIPS_OUT);
        chk("sweep_state4", st4, FIPS_OUT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
